// File: rtl/decode_execute_register.sv
// Decode-to-execute pipeline register with load-use bubble insertion,
// flush/stall handling and a saturating bubble counter.
module decode_execute_register #(
    parameter int DATAWIDTH    = 32,
    parameter int REGADDRWIDTH = 4,
    parameter int CNTWIDTH     = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    validD,
    input  logic                    writeEnableDD,
    input  logic                    writeDataEnableMD,
    input  logic                    resultSelectorWBD,
    input  logic                    data2SelectorED,
    input  logic                    outFlagD,
    input  logic [2:0]              aluControlED,
    input  logic [DATAWIDTH-1:0]    rd1D,
    input  logic [DATAWIDTH-1:0]    rd2D,
    input  logic [DATAWIDTH-1:0]    immD,
    input  logic [REGADDRWIDTH-1:0] rs1D,
    input  logic [REGADDRWIDTH-1:0] rs2D,
    input  logic [REGADDRWIDTH-1:0] rdD,
    input  logic                    stallE,
    input  logic                    flushE,
    output logic                    validE,
    output logic                    writeEnableDE,
    output logic                    writeDataEnableME,
    output logic                    resultSelectorWBE,
    output logic                    data2SelectorEE,
    output logic                    outFlagE,
    output logic [2:0]              aluControlEE,
    output logic [DATAWIDTH-1:0]    rd1E,
    output logic [DATAWIDTH-1:0]    rd2E,
    output logic [DATAWIDTH-1:0]    immE,
    output logic [REGADDRWIDTH-1:0] rs1E,
    output logic [REGADDRWIDTH-1:0] rs2E,
    output logic [REGADDRWIDTH-1:0] rdE,
    output logic                    loadUseStall,
    output logic [CNTWIDTH-1:0]     bubbleCount
);

    logic                    r_valid;
    logic                    r_we;
    logic                    r_wdm;
    logic                    r_rsel;
    logic                    r_d2sel;
    logic                    r_oflag;
    logic [2:0]              r_alu;
    logic [DATAWIDTH-1:0]    r_rd1;
    logic [DATAWIDTH-1:0]    r_rd2;
    logic [DATAWIDTH-1:0]    r_imm;
    logic [REGADDRWIDTH-1:0] r_rs1;
    logic [REGADDRWIDTH-1:0] r_rs2;
    logic [REGADDRWIDTH-1:0] r_rd;
    logic [CNTWIDTH-1:0]     r_cnt;

    logic w_hazard;
    logic w_bubble;
    logic w_load;

    // A load in E whose destination feeds either source of the D instruction.
    assign w_hazard = r_valid & r_we & r_rsel & validD &
                      ((r_rd == rs1D) | (r_rd == rs2D));
    assign loadUseStall = w_hazard & ~stallE;
    assign w_bubble     = flushE | loadUseStall;
    assign w_load       = ~flushE & ~stallE & ~loadUseStall;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= 1'b0;
            r_we    <= 1'b0;
            r_wdm   <= 1'b0;
            r_rsel  <= 1'b0;
            r_d2sel <= 1'b0;
            r_oflag <= 1'b0;
            r_alu   <= '0;
            r_rd1   <= '0;
            r_rd2   <= '0;
            r_imm   <= '0;
            r_rs1   <= '0;
            r_rs2   <= '0;
            r_rd    <= '0;
        end else if (w_bubble) begin
            r_valid <= 1'b0;
            r_we    <= 1'b0;
            r_wdm   <= 1'b0;
            r_rsel  <= 1'b0;
            r_d2sel <= 1'b0;
            r_oflag <= 1'b0;
            r_alu   <= '0;
            r_rd1   <= '0;
            r_rd2   <= '0;
            r_imm   <= '0;
            r_rs1   <= '0;
            r_rs2   <= '0;
            r_rd    <= '0;
        end else if (w_load) begin
            // An empty decode slot carries data but no side-effecting controls.
            r_valid <= validD;
            r_we    <= validD & writeEnableDD;
            r_wdm   <= validD & writeDataEnableMD;
            r_rsel  <= validD & resultSelectorWBD;
            r_d2sel <= validD & data2SelectorED;
            r_oflag <= validD & outFlagD;
            r_alu   <= validD ? aluControlED : 3'b000;
            r_rd1   <= rd1D;
            r_rd2   <= rd2D;
            r_imm   <= immD;
            r_rs1   <= rs1D;
            r_rs2   <= rs2D;
            r_rd    <= rdD;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (w_bubble && (r_cnt != {CNTWIDTH{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign validE            = r_valid;
    assign writeEnableDE     = r_we;
    assign writeDataEnableME = r_wdm;
    assign resultSelectorWBE = r_rsel;
    assign data2SelectorEE   = r_d2sel;
    assign outFlagE          = r_oflag;
    assign aluControlEE      = r_alu;
    assign rd1E              = r_rd1;
    assign rd2E              = r_rd2;
    assign immE              = r_imm;
    assign rs1E              = r_rs1;
    assign rs2E              = r_rs2;
    assign rdE               = r_rd;
    assign bubbleCount       = r_cnt;

endmodule

// File: doc/decode_execute_register.md
Name: decode_execute_register

Overview:
- Pipeline register between the decode stage (opcode decoder plus register file read) and the execute stage (ALU).
- Captures the decoder's control bits, operand data, immediate and register addresses each cycle.
- Inserts bubbles on flush or load-use hazard and holds on an external stall.
- Keeps a saturating count of inserted bubbles for performance debugging.

Parameters:
- DATAWIDTH, 32, width of operand and immediate data.
- REGADDRWIDTH, 4, width of register-file addresses.
- CNTWIDTH, 16, width of the bubble counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- validD  input  1  decode slot holds a real instruction.
- writeEnableDD  input  1  register-file write enable from decoder.
- writeDataEnableMD  input  1  data-memory write enable from decoder.
- resultSelectorWBD  input  1  writeback select from decoder; 1 = memory load.
- data2SelectorED  input  1  ALU operand-B select from decoder; 1 = immediate.
- outFlagD  input  1  output-instruction flag from decoder.
- aluControlED  input  3  ALU operation code from decoder.
- rd1D, rd2D  input  DATAWIDTH  register-file read data.
- immD  input  DATAWIDTH  extended immediate.
- rs1D, rs2D, rdD  input  REGADDRWIDTH  source and destination register addresses.
- stallE  input  1  hold request from downstream.
- flushE  input  1  branch-taken flush request.
- validE  output  1  execute slot holds a real instruction.
- writeEnableDE, writeDataEnableME, resultSelectorWBE, data2SelectorEE, outFlagE  output  1 each  registered control bits.
- aluControlEE  output  3  registered ALU operation code.
- rd1E, rd2E, immE  output  DATAWIDTH  registered data.
- rs1E, rs2E, rdE  output  REGADDRWIDTH  registered addresses.
- loadUseStall  output  1  combinational; fetch and decode must hold while it is 1.
- bubbleCount  output  CNTWIDTH  saturating count of inserted bubbles.

Behaviour:
- Reset (rst=0, asynchronous):
  - All outputs go to 0, including aluControlEE=000, validE=0 and bubbleCount=0.
  - An X on data2SelectorED is never propagated out of reset.
- Load-use detect, combinational:
  - loadUseStall = validE & writeEnableDE & resultSelectorWBE & validD & ((rdE==rs1D) | (rdE==rs2D)).
  - loadUseStall is forced to 0 while stallE=1, because no bubble can enter.
- Per-edge update, priority high to low:
  1. flushE=1: load a bubble (see below); bubbleCount increments. flushE overrides stallE.
  2. stallE=1: hold every registered output unchanged; bubbleCount unchanged.
  3. loadUseStall=1: load a bubble; bubbleCount increments. The decode instruction is not lost, because upstream holds it.
  4. Otherwise: load every D input into the matching E output. Latency is exactly 1 cycle.
- Bubble contents:
  - validE=0, all control bits 0, aluControlEE=000.
  - Data and address outputs are cleared to 0.
  - A bubble can never write the register file or memory, nor raise outFlagE.
- Invalid decode slot: when validD=0 on a normal load, the E control outputs are forced to 0 and validE=0.
  - This does not count as a bubble and bubbleCount does not increment.
- Counter: saturates at all-ones and holds there; it never wraps.
- Back-to-back hazard: after one bubble validE=0, so loadUseStall drops. A load-use pair therefore costs exactly one bubble.
- Mid-operation reset: state clears immediately without waiting for clk. The first edge after rst rises performs a normal load.

Test Plan:
- Reset, then validD=1, writeEnableDD=1, aluControlED=000, rd1D=5, rd2D=7, rdD=3.
  - Required: next cycle validE=1, writeEnableDE=1, rd1E=5, rd2E=7, rdE=3; bubbleCount=0.
- Load into r2 (resultSelectorWBD=1, writeEnableDD=1, rdD=2), followed by an add with rs1D=2.
  - Required: loadUseStall=1 for one cycle.
  - Required: the following cycle validE=0 and all E controls 0; then the add appears; bubbleCount=1.
- stallE=1 for 3 cycles with changing D inputs.
  - Required: E outputs frozen at the prior instruction; loadUseStall=0; bubbleCount unchanged.
- flushE=1 and stallE=1 together while a store (writeDataEnableMD=1) is in decode.
  - Required: next cycle writeDataEnableME=0, validE=0; bubbleCount +1.
- Preload bubbleCount to all-ones via 2^CNTWIDTH flushes, then one more flush.
  - Required: count stays at all-ones.
- Assert rst low asynchronously between edges while validE=1.
  - Required: all outputs 0 before the next edge.
  - Required: after release, a normal load resumes on the first edge.
